// File: rtl/axi_pack.sv
// Shared AXI4-Lite types, response codes and address-to-word-index helper.
package axi_pack;

  typedef logic [2:0] prot_type;
  typedef logic [1:0] resp_type;

  localparam resp_type RESP_OKAY   = 2'b00;
  localparam resp_type RESP_EXOKAY = 2'b01;
  localparam resp_type RESP_SLVERR = 2'b10;
  localparam resp_type RESP_DECERR = 2'b11;

  // Byte address to word index; only 32- and 64-bit data buses are supported.
  function automatic int unsigned word_index(input logic [63:0] addr,
                                             input int unsigned data_width);
    return 32'(addr >> ((data_width == 64) ? 3 : 2));
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with SLAVE and MASTER views.
interface AXI4_LITE #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  import axi_pack::*;

  logic [ADDR_WIDTH-1:0]     awaddr;
  prot_type                  awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  resp_type                  bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_WIDTH-1:0]     araddr;
  prot_type                  arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  resp_type                  rresp;
  logic                      rvalid;
  logic                      rready;

  modport SLAVE (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport MASTER (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank responder with independent write and read FSMs.
// Build option: AXI4_LITE_REG_DECERR_EN selects DECERR (else SLVERR) for out-of-range accesses.
module axi4_lite_reg_slave
  import axi_pack::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  AXI4_LITE.SLAVE                        s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI4_LITE_REG_DECERR_EN
  localparam resp_type RESP_OOR = RESP_DECERR;
`else
  localparam resp_type RESP_OOR = RESP_SLVERR;
`endif

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Write path
  wstate_t               r_wstate, w_wstate_nxt;
  logic                  r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
  logic                  r_awready, r_wready, w_awready_nxt, w_wready_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  resp_type              r_bresp;
  logic                  w_aw_hs, w_w_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_wr_in_range;
  logic [IDX_W-1:0]      w_wr_idx;

  // Read path
  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, w_arready_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_type              r_rresp;
  logic                  w_ar_hs;
  logic                  w_rd_in_range;
  logic [IDX_W-1:0]      w_rd_idx;

  logic                  w_unused;

  assign w_unused = ^{s_axi.awprot, s_axi.arprot};

  assign w_aw_hs = s_axi.awvalid & r_awready;
  assign w_w_hs  = s_axi.wvalid  & r_wready;

  // A held channel takes priority; the live bus value is used on its handshake cycle.
  assign w_waddr = r_aw_held ? r_awaddr : s_axi.awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : s_axi.wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : s_axi.wstrb;

  assign w_wr_in_range = word_index(64'(w_waddr), DATA_WIDTH) < NUM_REGS;
  assign w_wr_idx      = IDX_W'(word_index(64'(w_waddr), DATA_WIDTH));

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_commit      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) w_aw_held_nxt = 1'b1;
        if (w_w_hs)  w_w_held_nxt  = 1'b1;
        if ((r_aw_held | w_aw_hs) && (r_w_held | w_w_hs)) begin
          w_commit      = 1'b1;
          w_wstate_nxt  = W_RESP;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
        end else begin
          w_awready_nxt = ~w_aw_held_nxt;
          w_wready_nxt  = ~w_w_held_nxt;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_wstate_nxt  = W_IDLE;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      if (w_aw_hs) r_awaddr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
      if (w_commit) r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_OOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (w_commit && w_wr_in_range) begin
        reg_wr_pulse[w_wr_idx] <= 1'b1;
        for (int unsigned k = 0; k < STRB_W; k++) begin
          if (w_wstrb[k]) r_regs[w_wr_idx][k*8 +: 8] <= w_wdata[k*8 +: 8];
        end
      end
    end
  end

  assign w_ar_hs       = s_axi.arvalid & r_arready;
  assign w_rd_in_range = word_index(64'(s_axi.araddr), DATA_WIDTH) < NUM_REGS;
  assign w_rd_idx      = IDX_W'(word_index(64'(s_axi.araddr), DATA_WIDTH));

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) w_rstate_nxt  = R_DATA;
        else         w_arready_nxt = 1'b1;
      end
      R_DATA: begin
        if (s_axi.rready) begin
          w_rstate_nxt  = R_IDLE;
          w_arready_nxt = 1'b1;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // r_regs is sampled before the same-edge write lands, so a racing read sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
        r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_OOR;
      end
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = (r_wstate == W_RESP);
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = (r_rstate == R_DATA);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed and randomized bench for axi4_lite_reg_slave against an array-based register model.
module tb_axi4_lite_reg_slave;
  import axi_pack::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;

`ifdef AXI4_LITE_REG_DECERR_EN
  localparam logic [1:0] OOR = 2'b11;
`else
  localparam logic [1:0] OOR = 2'b10;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;

  AXI4_LITE #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .s_axi(bus), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [NR];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned idx_of(input logic [7:0] addr);
    return 32'(addr) / 4;
  endfunction

  function automatic logic [255:0] exp_q();
    logic [255:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [7:0] addr);
    return (idx_of(addr) < NR) ? 2'b00 : OOR;
  endfunction

  function automatic logic [7:0] exp_pulse(input logic [7:0] addr);
    return (idx_of(addr) < NR) ? 8'(1 << idx_of(addr)) : 8'h00;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] addr);
    return (idx_of(addr) < NR) ? model[idx_of(addr)] : 32'h0;
  endfunction

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask = '0;
    for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
    if (idx_of(addr) < NR) model[idx_of(addr)] = (model[idx_of(addr)] & ~mask) | (data & mask);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned aw_lag, input int unsigned w_lag, input int unsigned b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int unsigned c = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.awprot = 3'($urandom);
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && c >= aw_lag;
      bus.wvalid  = !w_done && c >= w_lag;
      if (w_done && !aw_done) check("wready_while_held", 256'(bus.wready), 256'(0));
      if (aw_done && !w_done) check("awready_while_held", 256'(bus.awready), 256'(0));
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      tick();
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      c++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    check("write_hs_done", 256'({aw_done, w_done}), 256'(2'b11));
    model_write(addr, data, strb);
    check("bvalid", 256'(bus.bvalid), 256'(1));
    check("bresp", 256'(bus.bresp), 256'(exp_resp(addr)));
    check("wr_pulse", 256'(reg_wr_pulse), 256'(exp_pulse(addr)));
    check("reg_q", 256'(reg_q), exp_q());
    for (int unsigned i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", 256'(bus.bvalid), 256'(1));
      check("bresp_hold", 256'(bus.bresp), 256'(exp_resp(addr)));
      check("awready_in_resp", 256'({bus.awready, bus.wready}), 256'(0));
      check("pulse_one_cycle", 256'(reg_wr_pulse), 256'(0));
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    check("bvalid_drop", 256'(bus.bvalid), 256'(0));
    check("ready_after_b", 256'({bus.awready, bus.wready}), 256'(2'b11));
    check("pulse_clear", 256'(reg_wr_pulse), 256'(0));
  endtask

  task automatic axi_read(input logic [7:0] addr, input int unsigned r_dly);
    bit got = 0;
    int unsigned c = 0;
    bus.araddr = addr; bus.arprot = 3'($urandom); bus.arvalid = 1;
    while (!got && c < 40) begin
      got = bus.arready;
      tick();
      c++;
    end
    bus.arvalid = 0;
    check("ar_hs_done", 256'(got), 256'(1));
    check("rvalid", 256'(bus.rvalid), 256'(1));
    check("rdata", 256'(bus.rdata), 256'(exp_rd(addr)));
    check("rresp", 256'(bus.rresp), 256'(exp_resp(addr)));
    for (int unsigned i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold", 256'(bus.rvalid), 256'(1));
      check("rdata_hold", 256'(bus.rdata), 256'(exp_rd(addr)));
      check("rresp_hold", 256'(bus.rresp), 256'(exp_resp(addr)));
      check("arready_in_data", 256'(bus.arready), 256'(0));
    end
    bus.rready = 1;
    tick();
    bus.rready = 0;
    check("rvalid_drop", 256'(bus.rvalid), 256'(0));
    check("arready_after_r", 256'(bus.arready), 256'(1));
  endtask

  initial begin
    rst = 1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    repeat (3) tick();
    check("rst_readys", 256'({bus.awready, bus.wready, bus.arready}), 256'(0));
    check("rst_valids", 256'({bus.bvalid, bus.rvalid}), 256'(0));
    check("rst_resps", 256'({bus.bresp, bus.rresp}), 256'(0));
    check("rst_rdata", 256'(bus.rdata), 256'(0));
    check("rst_reg_q", 256'(reg_q), 256'(0));
    check("rst_pulse", 256'(reg_wr_pulse), 256'(0));
    rst = 0;
    tick();
    check("readys_after_rst", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));

    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg1_value", 256'(reg_q[63:32]), 256'(32'hDEADBEEF));
    axi_read(8'h04, 0);

    axi_write(8'h10, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(8'h10, 32'h000000AA, 4'h1, 3, 0, 0);
    check("skewed_merge", 256'(reg_q[159:128]), 256'(32'h112233AA));

    axi_write(8'h20, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(8'h20, 0);

    axi_write(8'h08, 32'h5A5A1234, 4'hF, 0, 0, 5);
    axi_read(8'h08, 5);

    axi_write(8'h00, 32'h1, 4'hF, 0, 0, 0);
    bus.awaddr = 8'h00; bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.araddr = 8'h00;
    bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    check("race_readys", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    check("race_rdata_old", 256'(bus.rdata), 256'(32'h1));
    check("race_bvalid", 256'({bus.bvalid, bus.rvalid}), 256'(2'b11));
    model_write(8'h00, 32'h2, 4'hF);
    check("race_reg_q", 256'(reg_q), exp_q());
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    axi_read(8'h00, 0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 39));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2));
    end

    bus.awaddr = 8'h04; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    check("pre_rst_bvalid", 256'(bus.bvalid), 256'(1));
    rst = 1;
    tick();
    for (int i = 0; i < NR; i++) model[i] = '0;
    check("midrst_valids", 256'({bus.bvalid, bus.rvalid}), 256'(0));
    check("midrst_reg_q", 256'(reg_q), exp_q());
    check("midrst_readys", 256'({bus.awready, bus.wready, bus.arready}), 256'(0));
    rst = 0;
    tick();
    check("midrst_readys_back", 256'({bus.awready, bus.wready, bus.arready}), 256'(3'b111));
    axi_read(8'h04, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
